// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store to word-addressed memory adapter.
// Turns byte-addressed B/H/W requests into word beats with byte enables and
// lane-shifted write data, and aligns/extends load data on the way back.
// Compile-time option: define LSU_MISALIGNED_EN to split word-crossing
// accesses into two beats; left undefined, misaligned accesses are rejected.
module load_store_unit #(
  parameter int ADDR_W        = 32,
  parameter bit ERR_ON_BAD_F3 = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [3:0]        mem_be
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  // Unsupported encodings; BU/HU exist only for loads.
  function automatic logic f3_bad(input logic [2:0] f3, input logic st);
    case (f3)
      3'b000, 3'b001, 3'b010: f3_bad = 1'b0;
      3'b100, 3'b101:         f3_bad = st;
      default:                f3_bad = 1'b1;
    endcase
  endfunction

  // Access size in bytes; unsupported encodings behave as a full word.
  function automatic logic [2:0] f3_bytes(input logic [2:0] f3, input logic st);
    if (f3_bad(f3, st))            f3_bytes = 3'd4;
    else if (f3[1:0] == 2'b00)     f3_bytes = 3'd1;
    else if (f3[1:0] == 2'b01)     f3_bytes = 3'd2;
    else                           f3_bytes = 3'd4;
  endfunction

  state_t            r_state, w_next;
  logic              r_store, r_err;
  logic [2:0]        r_f3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata, r_lo;

  // Accept-time decode, done on the raw request inputs.
  logic w_req_bad, w_req_err;
  assign w_req_bad = ERR_ON_BAD_F3 && f3_bad(req_funct3, req_store);
`ifdef LSU_MISALIGNED_EN
  assign w_req_err = w_req_bad;
`else
  logic [2:0] w_req_bytes;
  logic       w_req_mis;
  assign w_req_bytes = f3_bytes(req_funct3, req_store);
  assign w_req_mis   = (w_req_bytes == 3'd2 && req_addr[0]) ||
                       (w_req_bytes == 3'd4 && req_addr[1:0] != 2'b00);
  assign w_req_err   = w_req_bad || w_req_mis;
`endif

  // Decode of the latched request used by the beats and the response.
  logic [2:0]        w_bytes;
  logic [3:0]        w_mask;
  logic [1:0]        w_off;
  logic              w_sign;
  logic [ADDR_W-1:0] w_waddr;
  logic [3:0]        w_be0;
  logic [31:0]       w_wd0, w_sh, w_ext;
  assign w_bytes = f3_bytes(r_f3, r_store);
  assign w_mask  = (w_bytes == 3'd1) ? 4'b0001 : (w_bytes == 3'd2) ? 4'b0011 : 4'b1111;
  assign w_off   = r_addr[1:0];
  assign w_sign  = !r_f3[2];
  assign w_waddr = {r_addr[ADDR_W-1:2], 2'b00};

`ifdef LSU_MISALIGNED_EN
  // The 8-lane / 64-bit views carry the spill into the next word for BEAT1.
  logic [31:0] r_hi;
  logic [7:0]  w_be8;
  logic [63:0] w_wd64;
  logic [3:0]  w_be1;
  logic [31:0] w_wd1;
  logic        w_cross;
  assign w_be8   = {4'b0000, w_mask} << w_off;
  assign w_wd64  = {32'd0, r_wdata} << {w_off, 3'b000};
  assign w_be0   = w_be8[3:0];
  assign w_be1   = w_be8[7:4];
  assign w_wd0   = w_wd64[31:0];
  assign w_wd1   = w_wd64[63:32];
  assign w_cross = ({1'b0, w_off} + w_bytes) > 3'd4;
  assign w_sh    = 32'({r_hi, r_lo} >> {w_off, 3'b000});
`else
  assign w_be0   = w_mask << w_off;
  assign w_wd0   = r_wdata << {w_off, 3'b000};
  assign w_sh    = r_lo >> {w_off, 3'b000};
`endif

  // Truncate the aligned load to its size, then sign/zero extend.
  always_comb begin
    w_ext = w_sh;
    case (w_bytes)
      3'd1:    w_ext = {{24{w_sign & w_sh[7]}}, w_sh[7:0]};
      3'd2:    w_ext = {{16{w_sign & w_sh[15]}}, w_sh[15:0]};
      default: w_ext = w_sh;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Request capture on accept and load-data capture during each beat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_store <= 1'b0;
      r_err   <= 1'b0;
      r_f3    <= 3'd0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_lo    <= 32'd0;
`ifdef LSU_MISALIGNED_EN
      r_hi    <= 32'd0;
`endif
    end else begin
      if (r_state == IDLE && req_valid) begin
        r_store <= req_store;
        r_f3    <= req_funct3;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_err   <= w_req_err;
      end
      if (r_state == BEAT0 && !r_store) r_lo <= mem_rdata;
`ifdef LSU_MISALIGNED_EN
      if (r_state == BEAT1 && !r_store) r_hi <= mem_rdata;
`endif
    end
  end

  // Next state and all outputs; everything idles at zero except req_ready.
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = 32'd0;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = w_req_err ? RESP : BEAT0;
      end
      BEAT0: begin
        mem_addr  = w_waddr;
        mem_we    = r_store;
        mem_be    = r_store ? w_be0 : 4'b0000;
        mem_wdata = r_store ? w_wd0 : 32'd0;
`ifdef LSU_MISALIGNED_EN
        w_next    = w_cross ? BEAT1 : RESP;
`else
        w_next    = RESP;
`endif
      end
`ifdef LSU_MISALIGNED_EN
      BEAT1: begin
        mem_addr  = w_waddr + ADDR_W'(4);
        mem_we    = r_store;
        mem_be    = r_store ? w_be1 : 4'b0000;
        mem_wdata = r_store ? w_wd1 : 32'd0;
        w_next    = RESP;
      end
`endif
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = r_err;
        rsp_rdata = (r_store || r_err) ? 32'd0 : w_ext;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's execute stage and the unified word-addressed memory.
- Converts RV32I load/store requests (funct3-encoded size and sign) into word accesses with byte enables and lane-shifted write data.
- Loads: extracts, aligns and sign/zero-extends read data.
- Misaligned accesses are either split into two word beats or rejected, selected at compile time.

Parameters:
ADDR_W, 32, width of request and memory address
ERR_ON_BAD_F3, 1, when 1 an unsupported funct3 returns rsp_err; when 0 it is treated as LW/SW

Ports:
clk  input  1  system clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
req_valid  input  1  core presents a request
req_ready  output  1  LSU can accept a request (high only in IDLE)
req_store  input  1  1 = store, 0 = load
req_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, right-justified
rsp_valid  output  1  one-cycle pulse, response complete
rsp_rdata  output  32  extended load data (0 for stores/errors)
rsp_err  output  1  request rejected, no memory write performed
mem_addr  output  ADDR_W  word-aligned address to memory (bits [1:0] = 0)
mem_wdata  output  32  lane-shifted store data
mem_rdata  input  32  combinational read data for mem_addr
mem_we  output  1  write strobe
mem_be  output  4  byte enables, bit n = byte lane n

Behaviour:
- Reset (async, resetn low): state IDLE; all outputs 0 except req_ready=1; capture registers cleared. Asserting reset mid-access aborts it; no further mem_we is produced.
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch store/funct3/addr/wdata, then decode:
    - Bad funct3 (ERR_ON_BAD_F3=1), or misaligned with feature off: go to RESP with err flag set.
    - Otherwise go to BEAT0.
- BEAT0:
  - mem_addr = {addr[ADDR_W-1:2],2'b00}.
  - Store: mem_we=1, mem_be = size_mask << off, mem_wdata = wdata << 8*off.
  - Load: mem_we=0, capture mem_rdata into lo register this cycle.
  - Next state: BEAT1 if off+size > 4, else RESP.
- BEAT1 (split only):
  - mem_addr = word address + 4, wrapping modulo 2^ADDR_W.
  - Store: mem_be = size_mask >> (4-off), mem_wdata = wdata >> 8*(4-off).
  - Load: capture mem_rdata into hi register.
  - Next state: RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle, then IDLE.
  - Load data = ({hi,lo} >> 8*off), truncated to size; sign-extended for B/H, zero-extended for BU/HU; W passes through.
  - Stores: rsp_rdata=0.
- Definitions: size_mask B=0001, H=0011, W=1111; off = addr[1:0]; size in bytes = 1/2/4.
- Latency, accept cycle = 0:
  - Aligned access: mem access in cycle 1, rsp_valid in cycle 2.
  - Split access: beats in cycles 1 and 2, rsp_valid in cycle 3.
  - Error: rsp_valid in cycle 1.
- mem_we and mem_be are 0 in IDLE, RESP and during loads.
- No new request is accepted until the cycle after rsp_valid (req_ready low in BEAT0/BEAT1/RESP).
- Only one outstanding request.
- Req inputs are sampled only on acceptance and may change afterwards.
- BU/HU with req_store=1 is bad funct3.

Optional Feature:
- Macro: LSU_MISALIGNED_EN.
- Defined: accesses crossing a word boundary (H at off 3, W at off 1..3) are split into BEAT0/BEAT1 as above.
  - H at off 1..2 stays single-beat.
- Undefined: natural alignment is required.
  - Misaligned cases: H at odd off, W at off != 0.
  - These go straight to RESP with rsp_err=1 and rsp_rdata=0, with no memory access.
  - BEAT1 is not synthesised.

Test Plan:
1. Reset low mid-BEAT0 of SW to 0x100 -> mem_we drops immediately, req_ready=1, memory word 0x100 unchanged after reset release.
2. SB wdata=0x000000A5 to 0x102 -> one beat: mem_addr=0x100, mem_be=0100, mem_wdata=0x00A50000; rsp_valid at cycle 2, rsp_err=0.
3. Memory[0x200]=0x8081F0F1, LB @0x201 -> 0xFFFFFFF0; LBU @0x201 -> 0x000000F0; LH @0x202 -> 0xFFFF8081; LHU @0x202 -> 0x00008081.
4. Memory[0x300]=0x44332211, [0x304]=0x88776655, LW @0x302 -> with LSU_MISALIGNED_EN: mem_addr 0x300 then 0x304, rdata=0x66554433, rsp_valid at cycle 3; without it: rsp_err=1, rdata=0, rsp_valid at cycle 1, no mem access.
5. With LSU_MISALIGNED_EN, SH wdata=0xBEEF @0x103 -> beat0 be=1000 wdata=0xEF000000 @0x100; beat1 be=0001 wdata=0x000000BE @0x104.
6. Back-to-back req_valid held high with funct3=011 (ERR_ON_BAD_F3=1) then a valid LW @0x0 -> first rsp_err=1 with no mem_we; second accepted the cycle after rsp_valid and returns memory[0].
